// File: rtl/word_compare_ctrl_if.sv
// Request/result bundle for word_compare_ctrl: operands and start in,
// registered status and three-way comparison result out.
interface word_compare_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (
    output start, a, b,
    input  busy, done, gt, eq, lt
  );

  modport slave (
    input  start, a, b,
    output busy, done, gt, eq, lt
  );
endinterface

// File: rtl/word_compare_ctrl.sv
// Serial unsigned magnitude comparator: walks both operands MSB-first,
// two bits per cycle, and stops at the first differing slice.
module word_compare_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  word_compare_ctrl_if.slave bus
);

  localparam int unsigned SLICES = WIDTH / 2;
  localparam int unsigned CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

  logic             w_gt;
  logic             w_eq;

  // One shared 2-bit comparator looks only at the current MSB slice
  assign w_gt = r_a[WIDTH-1 -: 2] >  r_b[WIDTH-1 -: 2];
  assign w_eq = r_a[WIDTH-1 -: 2] == r_b[WIDTH-1 -: 2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_cnt   <= '0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_gt) begin
            r_gt    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (!w_eq) begin
            r_lt    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_cnt == LAST) begin
            r_eq    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_a   <= r_a << 2;
            r_b   <= r_b << 2;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.gt   = r_gt;
  assign bus.eq   = r_eq;
  assign bus.lt   = r_lt;

endmodule

// File: tb/tb_word_compare_ctrl.sv
// Directed bench for word_compare_ctrl: 8-bit latency/handshake cases plus
// an exhaustive 4-bit sweep against an unsigned reference.
module tb_word_compare_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  word_compare_ctrl_if #(.WIDTH(8)) bus8 ();
  word_compare_ctrl_if #(.WIDTH(4)) bus4 ();

  word_compare_ctrl #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  word_compare_ctrl #(.WIDTH(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done8(output int ticks, output int busy_n, output bit run_bad);
    ticks   = 0;
    busy_n  = 0;
    run_bad = 1'b0;
    while (bus8.done !== 1'b1 && ticks < 20) begin
      if (bus8.busy === 1'b1) busy_n++;
      if ({bus8.gt, bus8.eq, bus8.lt} !== 3'b000) run_bad = 1'b1;
      tick();
      ticks++;
    end
  endtask

  // Flags are packed {gt,eq,lt}; exp_ticks is the number of RUN cycles.
  task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input int exp_ticks, input logic [2:0] exp_flags);
    int ticks;
    int busy_n;
    bit run_bad;
    bus8.a     = av;
    bus8.b     = bv;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    wait_done8(ticks, busy_n, run_bad);
    chk({tag, "_latency"}, ticks, exp_ticks);
    chk({tag, "_busy_cycles"}, busy_n, exp_ticks);
    chk({tag, "_flags"}, {bus8.gt, bus8.eq, bus8.lt}, exp_flags);
    chk({tag, "_flags_clear_in_run"}, run_bad, 0);
    chk({tag, "_busy_with_done"}, bus8.busy, 0);
    tick();
    chk({tag, "_done_one_cycle"}, bus8.done, 0);
  endtask

  initial begin
    int         ticks;
    int         busy_n;
    bit         run_bad;
    bit         hold_bad;
    logic [3:0] av4;
    logic [3:0] bv4;
    logic [2:0] ref4;
    int         t4;

    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus4.start = 1'b0;
    bus4.a     = '0;
    bus4.b     = '0;
    tick();
    tick();
    chk("reset_outputs", {bus8.busy, bus8.done, bus8.gt, bus8.eq, bus8.lt}, 5'b0);
    rst = 1'b0;

    // Slice 0 decides
    do_op("c0_40", 8'hC0, 8'h40, 1, 3'b100);
    // Slice 3 decides
    do_op("5a_5b", 8'h5A, 8'h5B, 4, 3'b001);
    // Equal operands, then hold for 10 idle cycles
    do_op("a5_a5", 8'hA5, 8'hA5, 4, 3'b010);
    hold_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if ({bus8.done, bus8.busy, bus8.gt, bus8.eq, bus8.lt} !== 5'b00010) hold_bad = 1'b1;
      tick();
    end
    chk("a5_hold_10", hold_bad, 0);

    // start held high; operands change mid-RUN
    bus8.a     = 8'h10;
    bus8.b     = 8'h01;
    bus8.start = 1'b1;
    tick();
    bus8.a = 8'h00;
    bus8.b = 8'hFF;
    wait_done8(ticks, busy_n, run_bad);
    chk("hold_start_latency", ticks, 2);
    chk("hold_start_flags", {bus8.gt, bus8.eq, bus8.lt}, 3'b100);
    tick();
    chk("hold_start_idle", {bus8.busy, bus8.done}, 2'b00);
    chk("hold_start_kept", {bus8.gt, bus8.eq, bus8.lt}, 3'b100);
    tick();
    chk("back_to_back_accept", bus8.busy, 1);
    bus8.start = 1'b0;
    wait_done8(ticks, busy_n, run_bad);
    chk("back_to_back_latency", ticks, 1);
    chk("back_to_back_flags", {bus8.gt, bus8.eq, bus8.lt}, 3'b001);
    tick();

    // Reset during RUN
    bus8.a     = 8'hFF;
    bus8.b     = 8'hFF;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    chk("pre_reset_busy", bus8.busy, 1);
    rst = 1'b1;
    tick();
    chk("mid_reset_outputs", {bus8.busy, bus8.done, bus8.gt, bus8.eq, bus8.lt}, 5'b0);
    rst = 1'b0;
    do_op("after_reset", 8'hFF, 8'hFF, 4, 3'b010);

    // Exhaustive 4-bit sweep
    for (int i = 0; i < 256; i++) begin
      av4 = 4'(i >> 4);
      bv4 = 4'(i);
      ref4 = (av4 > bv4) ? 3'b100 : ((av4 == bv4) ? 3'b010 : 3'b001);
      bus4.a     = av4;
      bus4.b     = bv4;
      bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      t4 = 0;
      while (bus4.done !== 1'b1 && t4 < 10) begin
        tick();
        t4++;
      end
      chk($sformatf("w4_%0h_%0h", av4, bv4), {bus4.done, bus4.gt, bus4.eq, bus4.lt}, {1'b1, ref4});
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/word_compare_ctrl.md
WORD_COMPARE_CTRL -- requirements
Module: word_compare_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits; even, >= 2; compared 2 bits per cycle.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a comparison; sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  operand A, captured on the accepting edge.
REQ-006 SHALL have port: b  input  WIDTH  operand B, captured on the accepting edge.
REQ-007 SHALL have port: busy  output  1  high while in RUN.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-009 SHALL have port: gt  output  1  A > B (unsigned).
REQ-010 SHALL have port: eq  output  1  A == B.
REQ-011 SHALL have port: lt  output  1  A < B (unsigned).

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; the encoding is free.
REQ-013 SHALL, in IDLE with start=1 at an edge, capture a and b into internal shift registers, clear gt/eq/lt, zero the slice counter, and enter RUN.
REQ-014 SHALL ignore start in RUN and DONE; operand inputs are don't-care outside the accepting edge.
REQ-015 SHALL, at each RUN edge, compare the 2-bit MSB slices of the shift registers unsigned, using one shared 2-bit greater-than / equality datapath.
REQ-016 SHALL, on slice A > slice B: set gt=1, eq=0, lt=0 and enter DONE (early exit).
REQ-017 SHALL, on slice A < slice B: set lt=1, gt=0, eq=0 and enter DONE (early exit).
REQ-018 SHALL, on equal slices with the counter at WIDTH/2-1: set eq=1, gt=0, lt=0 and enter DONE.
REQ-019 SHALL, on equal slices otherwise: shift both registers left by 2, increment the counter, and stay in RUN.
REQ-020 SHALL keep exactly one of gt/eq/lt high after any completed comparison, and all three low from accept until done.
REQ-021 SHALL drive done=1 for exactly the one cycle spent in DONE, then return to IDLE unconditionally.
REQ-022 SHALL hold gt/eq/lt stable from done until the next accepted start.
REQ-023 SHALL have latency: the deciding slice index i (0 = MSB) gives done high i+2 cycles after the accepting edge's cycle; worst case WIDTH/2+1 (equal operands).
REQ-024 SHALL make back-to-back operation possible: start may be high in the cycle after done (IDLE) and is accepted; minimum spacing between accepts is i+3 cycles.
REQ-025 SHALL drive busy=1 only in RUN, never together with done.
REQ-026 SHALL register all outputs; no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, while rst=1 at an edge, force IDLE with busy=0, done=0, gt=0, eq=0, lt=0, and counter and shift registers cleared.
REQ-028 SHALL let rst take priority over start and over any RUN/DONE transition; reset mid-operation discards the comparison, with no done pulse.
REQ-029 SHALL accept start in the first cycle after rst deasserts.

Verification (WIDTH=8)
REQ-030 SHALL be verified with: a=8'hC0, b=8'h40, start 1 cycle -> slice 0 decides; done 2 cycles after accept; gt=1, eq=0, lt=0; busy high 1 cycle.
REQ-031 SHALL be verified with: a=8'h5A, b=8'h5B -> slice 3 decides; done 5 cycles after accept; lt=1; busy high 4 cycles.
REQ-032 SHALL be verified with: a=b=8'hA5 -> eq=1 after 4 RUN cycles; done exactly 1 cycle wide; outputs held for 10 idle cycles.
REQ-033 SHALL be verified with: start held high continuously, a=8'h10, b=8'h01 -> gt=1 result; next op accepted the cycle after done; start ignored while busy (operands changed mid-RUN do not affect the result).
REQ-034 SHALL be verified with: rst=1 during RUN of a=b=8'hFF -> all outputs 0 the next cycle, no done; a fresh start after rst deasserts completes normally.
REQ-035 SHALL be verified with: an exhaustive sweep over a 4-bit instance (WIDTH=4) of all 256 {a,b} pairs -> exactly one of gt/eq/lt set, matching an unsigned reference comparison.
